lc3b_mem_responder: RTL and testbench
=====================================

LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

Interface
REQ-001 Parameter LATENCY, default 3: cycles from first request cycle to mem_resp cycle; legal range 1..15.
REQ-002 Parameter ADDR_W, default 12: word-index width; array holds 2**ADDR_W 16-bit words.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_address  input  16  byte address (lc3b_word).
REQ-006 mem_read  input  1  read request, held by initiator until mem_resp.
REQ-007 mem_write  input  1  write request, held by initiator until mem_resp.
REQ-008 mem_byte_enable  input  2  write byte mask (lc3b_mem_wmask); bit0 = low byte, bit1 = high byte.
REQ-009 mem_wdata  input  16  write data.
REQ-010 mem_resp  output  1  one-cycle completion pulse.
REQ-011 mem_rdata  output  16  read data, valid in the mem_resp cycle.

Function
REQ-012 States IDLE, WAIT, RESP, TURN; mem_resp = 1 exactly in RESP.
REQ-013 IDLE: mem_read or mem_write high -> load counter with LATENCY-1; go to RESP if LATENCY = 1, else WAIT.
REQ-014 WAIT: decrement counter each cycle; enter RESP on the cycle after the counter reaches 1; for a request first seen in cycle t, mem_resp is high in cycle t+LATENCY.
REQ-015 RESP -> TURN unconditionally; TURN -> IDLE unconditionally, ignoring requests in TURN (one-cycle turnaround).
REQ-016 Word index = mem_address[ADDR_W:1]; mem_address[0] is ignored; bits above ADDR_W are ignored (aliasing wrap).
REQ-017 Read: mem_rdata is registered and loaded with the array word on the clock edge entering RESP; it holds its value outside RESP.
REQ-018 Write: the array is updated on the clock edge ending RESP, only for bytes whose mem_byte_enable bit is 1; mask 2'b00 completes with mem_resp and leaves the array unchanged.
REQ-019 Both mem_read and mem_write high: treated as a write; mem_rdata is not reloaded.
REQ-020 Request (read and write both low) dropped in WAIT or RESP: return to IDLE next cycle, no array update, no mem_resp.
REQ-021 Request type, address, mask and data are sampled each cycle; values present in the RESP cycle are used.
REQ-022 Array contents are never cleared by reset.

Reset
REQ-023 reset asserted: state = IDLE, counter = 0, mem_resp = 0, mem_rdata = 16'h0000, immediately and asynchronously.
REQ-024 reset mid-transaction aborts the transaction: no array write, no mem_resp.

Configuration
REQ-025 Macro LC3B_MEM_CHECK_EN defined: add output mem_err (1 bit, reset 0); mem_err pulses for one cycle when mem_read and mem_write are both high in any non-TURN cycle, or when mem_address changes while in WAIT or RESP.
REQ-026 Macro undefined: no mem_err port and no checking logic; all other behaviour is identical.

Structure
REQ-027 lc3b_word, lc3b_mem_wmask and a new state enum type, lc3b_memresp_state, are defined in lc3b_types.
REQ-028 One sub-module, lc3b_mem_array, implements the byte-enabled synchronous 2**ADDR_W x 16 array: one read port and one masked write port.

Verification
REQ-029 LATENCY=3; write 16'hBEEF to 16'h0040, mask 2'b11, then read 16'h0040 -> mem_resp in cycle t+3 for each transaction; read returns 16'hBEEF.
REQ-030 Memory holds 16'h1234 at 16'h0010; write 16'hAB00, mask 2'b10, then read -> 16'hAB34; with mask 2'b01 and wdata 16'h00CD, then read -> 16'hAB34 becomes 16'hABCD.
REQ-031 LATENCY=1; back-to-back read requests held continuously -> mem_resp pulses every 3 cycles (RESP, TURN, IDLE); mem_resp is never high for 2 consecutive cycles.
REQ-032 Write request dropped in the WAIT cycle -> no mem_resp; a later read of the same address returns the old data.
REQ-033 reset asserted in WAIT -> mem_resp = 0 and mem_rdata = 16'h0000 immediately; array unchanged; the next request completes in LATENCY cycles.
REQ-034 LC3B_MEM_CHECK_EN defined; mem_read and mem_write asserted together on 16'h0002 -> mem_err = 1 for one cycle and a write is performed; address changed 16'h0002 -> 16'h0004 in WAIT -> mem_err pulse.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b memory types, responder state enum and byte-merge helper
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_TURN
   } lc3b_memresp_state;

   // Merge new write data into an existing word, one byte lane per mask bit.
   function automatic lc3b_word apply_wmask(input lc3b_word old_word,
                                            input lc3b_word new_word,
                                            input lc3b_mem_wmask mask);
      lc3b_word merged;
      merged[7:0]  = mask[0] ? new_word[7:0]  : old_word[7:0];
      merged[15:8] = mask[1] ? new_word[15:8] : old_word[15:8];
      return merged;
   endfunction

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// rtl/lc3b_mem_responder_if.sv - LC-3b memory bus bundle; mem_err present only with LC3B_MEM_CHECK_EN
interface lc3b_mem_responder_if;
   import lc3b_types::*;

   lc3b_word      mem_address;
   logic          mem_read;
   logic          mem_write;
   lc3b_mem_wmask mem_byte_enable;
   lc3b_word      mem_wdata;
   logic          mem_resp;
   lc3b_word      mem_rdata;
`ifdef LC3B_MEM_CHECK_EN
   logic          mem_err;
`endif

   modport master (
`ifdef LC3B_MEM_CHECK_EN
      input  mem_err,
`endif
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  mem_resp, mem_rdata
   );

   modport slave (
`ifdef LC3B_MEM_CHECK_EN
      output mem_err,
`endif
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output mem_resp, mem_rdata
   );

endinterface

// File: rtl/lc3b_mem_array.sv
// rtl/lc3b_mem_array.sv - 2**ADDR_W x 16 storage, registered read port and byte-masked write port
module lc3b_mem_array
   import lc3b_types::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output lc3b_word          rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  lc3b_mem_wmask     wr_mask,
   input  lc3b_word          wr_data
);

   lc3b_word mem [2**ADDR_W];

   // Storage is intentionally outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= apply_wmask(mem[wr_addr], wr_data, wr_mask);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= 16'h0000;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lc3b_mem_responder.sv
// rtl/lc3b_mem_responder.sv - fixed-latency LC-3b memory responder; LC3B_MEM_CHECK_EN adds mem_err protocol checker
module lc3b_mem_responder
   import lc3b_types::*;
#(
   parameter int LATENCY = 3,
   parameter int ADDR_W  = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   lc3b_mem_responder_if.slave  mem
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   lc3b_memresp_state state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              req;
   logic              rd_en;
   logic              wr_en;
   logic [ADDR_W-1:0] word_idx;
   lc3b_word          rdata;

   assign req      = mem.mem_read | mem.mem_write;
   assign word_idx = mem.mem_address[ADDR_W:1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: state_d = req ? ST_TURN : ST_IDLE;
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A request withdrawn during RESP completes nothing: no pulse, no write.
   assign mem.mem_resp = (state_q == ST_RESP) && req;
   assign wr_en        = mem.mem_resp && mem.mem_write;
   assign rd_en        = (state_d == ST_RESP) && (state_q != ST_RESP)
                         && mem.mem_read && !mem.mem_write;
   assign mem.mem_rdata = rdata;

   lc3b_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_addr (word_idx),
      .rd_data (rdata),
      .wr_en   (wr_en),
      .wr_addr (word_idx),
      .wr_mask (mem.mem_byte_enable),
      .wr_data (mem.mem_wdata)
   );

`ifdef LC3B_MEM_CHECK_EN
   lc3b_word addr_q;
   logic     err_cond;
   logic     err_cond_q;
   logic     err_q;

   assign err_cond = (mem.mem_read && mem.mem_write && (state_q != ST_TURN))
                   || (((state_q == ST_WAIT) || (state_q == ST_RESP))
                       && (mem.mem_address != addr_q));

   // Rising edge of the violation condition gives a single-cycle pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= 16'h0000;
         err_cond_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         addr_q     <= mem.mem_address;
         err_cond_q <= err_cond;
         err_q      <= err_cond && !err_cond_q;
      end
   end

   assign mem.mem_err = err_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb/tb_lc3b_mem_responder.sv - directed self-checking bench for lc3b_mem_responder (LATENCY 3 and 1)
`timescale 1ns/1ps
module tb_lc3b_mem_responder;
   import lc3b_types::*;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   lc3b_mem_responder_if if3 ();
   lc3b_mem_responder_if if1 ();

   lc3b_mem_responder #(.LATENCY(3), .ADDR_W(12)) dut3 (
      .clk   (clk),
      .reset (reset),
      .mem   (if3.slave)
   );

   lc3b_mem_responder #(.LATENCY(1), .ADDR_W(12)) dut1 (
      .clk   (clk),
      .reset (reset),
      .mem   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef LC3B_MEM_CHECK_EN
   int err_cnt = 0;
   always @(negedge clk) if (if3.mem_err === 1'b1) err_cnt++;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive3(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] mask, input logic [15:0] wd);
      if3.mem_read        = rd;
      if3.mem_write       = wr;
      if3.mem_address     = addr;
      if3.mem_byte_enable = mask;
      if3.mem_wdata       = wd;
   endtask

   // Full transaction on the LATENCY=3 port; returns mem_rdata seen in the resp cycle.
   task automatic txn3(input string tag, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [1:0] mask, input logic [15:0] wd, output logic [15:0] rd_obs);
      int n;
      drive3(rd, wr, addr, mask, wd);
      n = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (if3.mem_resp === 1'b1) begin
            n = i;
            break;
         end
      end
      check({tag, "_latency"}, n, 3);
      rd_obs = if3.mem_rdata;
      @(posedge clk); #1;
      drive3(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      @(posedge clk); #1;
   endtask

   logic [15:0] rv;
   int          resp_seen;
   logic        prev_resp;

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      drive3(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_address = 16'h0000;
      if1.mem_byte_enable = 2'b00; if1.mem_wdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_resp", if3.mem_resp, 0);
      check("reset_rdata", if3.mem_rdata, 16'h0000);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // Full-word write then read back.
      txn3("w_beef", 1'b0, 1'b1, 16'h0040, 2'b11, 16'hBEEF, rv);
      txn3("r_beef", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, rv);
      check("r_beef_data", rv, 16'hBEEF);

      // Byte-lane writes.
      txn3("w_1234", 1'b0, 1'b1, 16'h0010, 2'b11, 16'h1234, rv);
      txn3("w_hi", 1'b0, 1'b1, 16'h0010, 2'b10, 16'hAB00, rv);
      txn3("r_ab34", 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, rv);
      check("r_ab34_data", rv, 16'hAB34);
      txn3("w_lo", 1'b0, 1'b1, 16'h0010, 2'b01, 16'h00CD, rv);
      txn3("r_abcd", 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, rv);
      check("r_abcd_data", rv, 16'hABCD);
      txn3("w_mask0", 1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF, rv);
      txn3("r_odd", 1'b1, 1'b0, 16'h0011, 2'b00, 16'h0000, rv);
      check("r_odd_addr_data", rv, 16'hABCD);
      txn3("r_alias", 1'b1, 1'b0, 16'h2010, 2'b00, 16'h0000, rv);
      check("r_alias_data", rv, 16'hABCD);

      // Write dropped in WAIT: no response and no array update.
      drive3(1'b0, 1'b1, 16'h0040, 2'b11, 16'h1111);
      @(posedge clk); #1;
      drive3(1'b0, 1'b0, 16'h0040, 2'b11, 16'h1111);
      resp_seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (if3.mem_resp === 1'b1) resp_seen++;
      end
      check("drop_no_resp", resp_seen, 0);
      txn3("r_after_drop", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, rv);
      check("r_after_drop_data", rv, 16'hBEEF);

      // Asynchronous reset while in WAIT.
      drive3(1'b0, 1'b1, 16'h0040, 2'b11, 16'h2222);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("rst_wait_resp", if3.mem_resp, 0);
      check("rst_wait_rdata", if3.mem_rdata, 16'h0000);
      drive3(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      txn3("r_after_rst", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, rv);
      check("r_after_rst_data", rv, 16'hBEEF);

      // Read and write together act as a write; rdata must not reload.
`ifdef LC3B_MEM_CHECK_EN
      err_cnt = 0;
      txn3("rw_both", 1'b1, 1'b1, 16'h0002, 2'b11, 16'h5555, rv);
      check("rw_both_err_pulses", err_cnt, 1);
      check("rw_both_rdata_held", rv, 16'hBEEF);
      txn3("r_both", 1'b1, 1'b0, 16'h0002, 2'b00, 16'h0000, rv);
      check("r_both_data", rv, 16'h5555);
      err_cnt = 0;
      drive3(1'b1, 1'b0, 16'h0002, 2'b00, 16'h0000);
      @(posedge clk); #1;
      if3.mem_address = 16'h0004;
      repeat (4) @(posedge clk);
      #1;
      drive3(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      check("addr_change_err", err_cnt, 1);
`else
      txn3("rw_both", 1'b1, 1'b1, 16'h0040, 2'b11, 16'h5555, rv);
      check("rw_both_rdata_held", rv, 16'hBEEF);
      txn3("r_both", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, rv);
      check("r_both_data", rv, 16'h5555);
`endif

      // LATENCY=1 with reads held continuously: RESP, TURN, IDLE repeating.
      if1.mem_read = 1'b1;
      if1.mem_address = 16'h0000;
      prev_resp = 1'b0;
      resp_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check($sformatf("lat1_resp_%0d", i), if1.mem_resp, (i % 3 == 0) ? 1 : 0);
         if (prev_resp === 1'b1 && if1.mem_resp === 1'b1) resp_seen++;
         prev_resp = if1.mem_resp;
      end
      check("lat1_no_back_to_back", resp_seen, 0);
      if1.mem_read = 1'b0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
